// File: rtl/control_cronometro.sv
// control_cronometro: MM:SS stopwatch controller.
// A run/pause FSM gates a prescaler whose terminal count advances a cascade
// of four BCD digits; a lap freeze holds the display while counting goes on.
module control_cronometro #(
   parameter int DIV     = 50,  // clk cycles per count tick
   parameter int PRESC_W = 6,   // prescaler width, 2**PRESC_W >= DIV
   parameter int LIM_U   = 9,   // terminal value of units digits
   parameter int LIM_D   = 5    // terminal value of tens digits
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] seg_u,
   output logic [3:0] seg_d,
   output logic [3:0] min_u,
   output logic [3:0] min_d,
   output logic       running,
   output logic       lap_active,
   output logic       tick,
   output logic       overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   typedef struct packed {
      logic [3:0] min_d;
      logic [3:0] min_u;
      logic [3:0] seg_d;
      logic [3:0] seg_u;
   } bcd_time_t;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
   localparam logic [3:0]         LU         = 4'(LIM_U);
   localparam logic [3:0]         LD         = 4'(LIM_D);

   state_t             state_q, state_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   bcd_time_t          digits_q, digits_d;
   bcd_time_t          disp_q, disp_d;
   logic               lap_q, lap_d;
   logic               tick_q, ovf_q;
   logic               adv, clr_ok, wrap_all;
   logic               c_su, c_sd, c_mu;

   // State register, prescaler, digits, display and registered pulses
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         presc_q  <= '0;
         digits_q <= '0;
         disp_q   <= '0;
         lap_q    <= 1'b0;
         tick_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         digits_q <= digits_d;
         disp_q   <= disp_d;
         lap_q    <= lap_d;
         tick_q   <= adv;
         ovf_q    <= adv && wrap_all;
      end
   end

   // Next-state, prescaler, BCD cascade and lap freeze logic
   // NOTE: every signal gets a default before any branch, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      digits_d = digits_q;
      lap_d    = lap_q;
      adv      = 1'b0;
      clr_ok   = 1'b0;
      c_su     = 1'b0;
      c_sd     = 1'b0;
      c_mu     = 1'b0;

      case (state_q)
         IDLE: begin
            if (clear) begin
               clr_ok = 1'b1;
            end else if (start_stop) begin
               state_d = RUN;
               presc_d = '0;
            end
         end
         RUN: begin
            if (start_stop) state_d = PAUSE;
            if (lap)        lap_d   = ~lap_q;
            if (presc_q >= PRESC_LAST) begin
               presc_d = '0;
               adv     = 1'b1;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         PAUSE: begin
            // clear beats start_stop; the partial tick in presc_q survives a resume
            if (clear) begin
               clr_ok = 1'b1;
            end else if (start_stop) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase

      // All carries resolve within this single edge
      c_su     = (digits_q.seg_u >= LU);
      c_sd     = c_su && (digits_q.seg_d >= LD);
      c_mu     = c_sd && (digits_q.min_u >= LU);
      wrap_all = c_mu && (digits_q.min_d >= LD);

      if (clr_ok) begin
         state_d  = IDLE;
         presc_d  = '0;
         digits_d = '0;
         lap_d    = 1'b0;
      end else if (adv) begin
         digits_d.seg_u = c_su ? 4'd0 : digits_q.seg_u + 4'd1;
         if (c_su) digits_d.seg_d = c_sd ? 4'd0 : digits_q.seg_d + 4'd1;
         if (c_sd) digits_d.min_u = c_mu ? 4'd0 : digits_q.min_u + 4'd1;
         if (c_mu) digits_d.min_d = wrap_all ? 4'd0 : digits_q.min_d + 4'd1;
      end

      // Hold only while the freeze was already active and stays active; the
      // capturing and releasing edges both load the value being written.
      disp_d = (lap_q && lap_d) ? disp_q : digits_d;
   end

   assign seg_u      = disp_q.seg_u;
   assign seg_d      = disp_q.seg_d;
   assign min_u      = disp_q.min_u;
   assign min_d      = disp_q.min_d;
   assign running    = (state_q == RUN);
   assign lap_active = lap_q;
   assign tick       = tick_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_control_cronometro.sv
// Testbench for control_cronometro (DIV=4): a seconds-count reference model
// feeds a per-cycle scoreboard, a vector table checks milestones, and
// hand-written sequences cover overflow and lap/pause interplay.
module tb_control_cronometro;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst, start_stop, clear, lap;
   logic [3:0] seg_u, seg_d, min_u, min_d;
   logic       running, lap_active, tick, overflow;

   control_cronometro #(
      .DIV(DIV), .PRESC_W(6), .LIM_U(9), .LIM_D(5)
   ) dut (
      .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
      .seg_u(seg_u), .seg_d(seg_d), .min_u(min_u), .min_d(min_d),
      .running(running), .lap_active(lap_active), .tick(tick), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] disp;
      logic        run;
      logic        lapa;
      logic        tck;
      logic        ovf;
   } obs_t;

   typedef struct {
      string      name;
      bit         r, ss, cl, lp;
      int         n;
      logic [15:0] exp_disp;
      bit         exp_run, exp_lap, exp_tick;
   } vec_t;

   obs_t sb_q[$];
   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model: time held as whole seconds, state as 0=idle 1=run 2=pause
   int m_state = 0, m_presc = 0, m_time = 0, m_disp = 0;
   bit m_lap = 0, m_tick = 0, m_ovf = 0;

   function automatic logic [15:0] to_bcd(input int s);
      return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
   endfunction

   function automatic obs_t model_obs();
      obs_t o;
      o.disp = to_bcd(m_disp);
      o.run  = (m_state == 1);
      o.lapa = m_lap;
      o.tck  = m_tick;
      o.ovf  = m_ovf;
      return o;
   endfunction

   function automatic obs_t dut_obs();
      obs_t o;
      o.disp = {min_d, min_u, seg_d, seg_u};
      o.run  = running;
      o.lapa = lap_active;
      o.tck  = tick;
      o.ovf  = overflow;
      return o;
   endfunction

   task automatic model_step(input bit r, input bit ss, input bit cl, input bit lp);
      bit adv, clr_ok, old_lap;
      int old_time;
      if (r) begin
         m_state = 0; m_presc = 0; m_time = 0; m_disp = 0;
         m_lap = 0; m_tick = 0; m_ovf = 0;
         return;
      end
      adv      = (m_state == 1) && (m_presc == DIV - 1);
      clr_ok   = cl && (m_state != 1);
      old_lap  = m_lap;
      old_time = m_time;
      m_tick   = adv;
      m_ovf    = adv && (old_time == 3599);
      if (m_state == 1) m_presc = adv ? 0 : m_presc + 1;
      if (clr_ok)   m_time = 0;
      else if (adv) m_time = (m_time + 1) % 3600;
      if (clr_ok)                      m_lap = 0;
      else if ((m_state == 1) && lp)   m_lap = !m_lap;
      if (!(old_lap && m_lap)) m_disp = m_time;
      case (m_state)
         0: if (!cl && ss) m_state = 1;
         1: if (ss) m_state = 2;
         default: if (cl) m_state = 0; else if (ss) m_state = 1;
      endcase
      if (clr_ok) m_presc = 0;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, push model expectation, compare after edge
   task automatic cyc(input bit r, input bit ss, input bit cl, input bit lp);
      obs_t e;
      @(negedge clk);
      rst = r; start_stop = ss; clear = cl; lap = lp;
      model_step(r, ss, cl, lp);
      sb_q.push_back(model_obs());
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check("scoreboard", 32'(dut_obs()), 32'(e));
      end
   endtask

   function automatic vec_t mk(input string name, input bit r, input bit ss, input bit cl,
                               input bit lp, input int n, input logic [15:0] d,
                               input bit run, input bit lpa, input bit tck);
      vec_t v;
      v.name = name; v.r = r; v.ss = ss; v.cl = cl; v.lp = lp; v.n = n;
      v.exp_disp = d; v.exp_run = run; v.exp_lap = lpa; v.exp_tick = tck;
      return v;
   endfunction

   initial begin
      rst = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;

      //                name             r  ss cl lp  n    disp      run lap tick
      tbl.push_back(mk("reset",          1, 0, 0, 0,  1, 16'h0000, 0, 0, 0));
      tbl.push_back(mk("start",          0, 1, 0, 0,  3, 16'h0000, 1, 0, 0));
      tbl.push_back(mk("first_tick",     0, 0, 0, 0,  0, 16'h0001, 1, 0, 1));
      tbl.push_back(mk("ten_seconds",    0, 0, 0, 0, 35, 16'h0010, 1, 0, 1));
      tbl.push_back(mk("reach_12",       0, 0, 0, 0,  7, 16'h0012, 1, 0, 1));
      tbl.push_back(mk("lap_on",         0, 0, 0, 1,  0, 16'h0012, 1, 1, 0));
      tbl.push_back(mk("frozen",         0, 0, 0, 0, 30, 16'h0012, 1, 1, 1));
      tbl.push_back(mk("lap_off",        0, 0, 0, 1,  0, 16'h0020, 1, 0, 0));
      tbl.push_back(mk("clear_in_run",   0, 0, 1, 0,  0, 16'h0020, 1, 0, 0));
      tbl.push_back(mk("keeps_counting", 0, 0, 0, 0,  1, 16'h0021, 1, 0, 1));
      tbl.push_back(mk("presc_to_1",     0, 0, 0, 0,  0, 16'h0021, 1, 0, 0));
      tbl.push_back(mk("pause_hold",     0, 1, 0, 0, 20, 16'h0021, 0, 0, 0));
      tbl.push_back(mk("resume",         0, 1, 0, 0,  0, 16'h0021, 1, 0, 0));
      tbl.push_back(mk("resume_p3",      0, 0, 0, 0,  0, 16'h0021, 1, 0, 0));
      tbl.push_back(mk("resume_adv",     0, 0, 0, 0,  0, 16'h0022, 1, 0, 1));
      tbl.push_back(mk("rst_again",      1, 0, 0, 0,  0, 16'h0000, 0, 0, 0));
      tbl.push_back(mk("run_to_7",       0, 1, 0, 0, 28, 16'h0007, 1, 0, 1));
      tbl.push_back(mk("pause_at_7",     0, 1, 0, 0,  0, 16'h0007, 0, 0, 0));
      tbl.push_back(mk("clear_and_ss",   0, 1, 1, 0,  0, 16'h0000, 0, 0, 0));
      tbl.push_back(mk("idle_stays",     0, 0, 0, 0,  2, 16'h0000, 0, 0, 0));
      tbl.push_back(mk("lap_in_idle",    0, 0, 0, 1,  0, 16'h0000, 0, 0, 0));
      tbl.push_back(mk("run_to_0341",    0, 1, 0, 0, 884, 16'h0341, 1, 0, 1));
      tbl.push_back(mk("lap_at_0341",    0, 0, 0, 1,  0, 16'h0341, 1, 1, 0));
      tbl.push_back(mk("rst_mid_count",  1, 1, 0, 0,  0, 16'h0000, 0, 0, 0));
      tbl.push_back(mk("after_rst",      0, 0, 0, 0,  3, 16'h0000, 0, 0, 0));

      foreach (tbl[i]) begin
         cyc(tbl[i].r, tbl[i].ss, tbl[i].cl, tbl[i].lp);
         repeat (tbl[i].n) cyc(0, 0, 0, 0);
         check(tbl[i].name, {13'd0, min_d, min_u, seg_d, seg_u, running, lap_active, tick},
               {13'd0, tbl[i].exp_disp, tbl[i].exp_run, tbl[i].exp_lap, tbl[i].exp_tick});
      end

      // Overflow: run to 59:58, then across the 59:59 -> 00:00 wrap
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      repeat (3598 * DIV) cyc(0, 0, 0, 0);
      check("at_5958", {min_d, min_u, seg_d, seg_u}, 16'h5958);
      repeat (DIV) cyc(0, 0, 0, 0);
      check("at_5959", {min_d, min_u, seg_d, seg_u, tick, overflow}, {16'h5959, 2'b10});
      repeat (DIV - 1) cyc(0, 0, 0, 0);
      check("pre_wrap", {min_d, min_u, seg_d, seg_u, tick, overflow}, {16'h5959, 2'b00});
      cyc(0, 0, 0, 0);
      check("wrap_0000", {min_d, min_u, seg_d, seg_u, tick, overflow}, {16'h0000, 2'b11});
      cyc(0, 0, 0, 0);
      check("ovf_one_cycle", {tick, overflow}, 2'b00);
      repeat (DIV - 1) cyc(0, 0, 0, 0);
      check("after_wrap", {min_d, min_u, seg_d, seg_u, running, tick, overflow},
            {16'h0001, 3'b110});

      // Lap frozen across pause, lap still toggles after resume, clear releases
      cyc(0, 0, 0, 1);
      check("lap2_on", {min_d, min_u, seg_d, seg_u, lap_active}, {16'h0001, 1'b1});
      repeat (3) cyc(0, 0, 0, 0);
      check("lap2_frozen", {min_d, min_u, seg_d, seg_u, tick}, {16'h0001, 1'b1});
      cyc(0, 1, 0, 0);
      check("pause_frozen", {min_d, min_u, seg_d, seg_u, running, lap_active},
            {16'h0001, 2'b01});
      cyc(0, 0, 0, 1);
      check("lap_in_pause", {lap_active}, 1'b1);
      cyc(0, 1, 0, 0);
      check("resume_frozen", {running, lap_active}, 2'b11);
      cyc(0, 0, 0, 1);
      check("lap2_off", {min_d, min_u, seg_d, seg_u, lap_active}, {16'h0002, 1'b0});
      cyc(0, 0, 0, 1);
      check("lap3_on", {min_d, min_u, seg_d, seg_u, lap_active}, {16'h0002, 1'b1});
      cyc(0, 1, 0, 0);
      check("pause_adv_frozen", {min_d, min_u, seg_d, seg_u, tick, lap_active},
            {16'h0002, 2'b11});
      cyc(0, 0, 1, 0);
      check("clear_release", {min_d, min_u, seg_d, seg_u, running, lap_active},
            {16'h0000, 2'b00});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
